data_parse: RTL

- Read-side counterpart of the packet writer in the ADC data path.
- On an fs/fd job it reads one packet back from packet RAM, starting at ram_data_init.
  - Checks the header nibble for the given btype.
  - Extracts the device fields.
  - For DATA packets, returns each chip's 64 ADC bytes into that chip's FIFO lane.
- Used for loopback self-test and on the host-facing receive side.

---
 rtl/data_parse_pkg.sv | 28 ++
 rtl/data_parse_adc_lane_demux.sv | 12 +
 rtl/data_parse.sv | 112 +++++++++++
 3 files changed

// File: rtl/data_parse_pkg.sv
// data_parse_pkg: packet codes, head nibbles and sizes shared by the ADC packet writer and reader.
package data_parse_pkg;
  localparam int DATA_LEN = 64;
  localparam int CHIP_NUM = 8;
  localparam int ADDR_W = 12;
  localparam logic [3:0] BAG_DLINK = 4'b1000;
  localparam logic [3:0] BAG_DTYPE = 4'b1001;
  localparam logic [3:0] BAG_DTEMP = 4'b1010;
  localparam logic [3:0] BAG_DATA0 = 4'b1101;
  localparam logic [3:0] BAG_DATA1 = 4'b1110;
  localparam logic [3:0] HEAD_DLINK = 4'hD;
  localparam logic [3:0] HEAD_DTYPE = 4'h1;
  localparam logic [3:0] HEAD_DTEMP = 4'h9;
  localparam logic [3:0] HEAD_DATA = 4'h3;
  localparam logic [11:0] DATA_DLINK = 12'h123;
  localparam logic [ADDR_W-1:0] DATA_ADDR_INIT = 12'hFE0;
  typedef enum logic [2:0] {IDLE, WAIT, READ, LAST, FLUSH, DONE} state_e;
  typedef enum logic [1:0] {K_DLINK, K_DTYPE, K_DTEMP, K_DATA} kind_e;
  function automatic logic btype_ok(input logic [3:0] b);
    return b inside {BAG_DLINK, BAG_DTYPE, BAG_DTEMP, BAG_DATA0, BAG_DATA1};
  endfunction
  function automatic kind_e kind_of(input logic [3:0] b);
    return b == BAG_DLINK ? K_DLINK : b == BAG_DTYPE ? K_DTYPE : b == BAG_DTEMP ? K_DTEMP : K_DATA;
  endfunction
  function automatic logic [3:0] head_of(input kind_e k);
    return k == K_DLINK ? HEAD_DLINK : k == K_DTYPE ? HEAD_DTYPE : k == K_DTEMP ? HEAD_DTEMP : HEAD_DATA;
  endfunction
endpackage

// File: rtl/data_parse_adc_lane_demux.sv
// adc_lane_demux: places one ADC byte on its chip lane (chip 0 = top lane) with a one-hot strobe.
module adc_lane_demux
  import data_parse_pkg::*;
(
  input  logic [$clog2(CHIP_NUM)-1:0] chip_i,
  input  logic [7:0]                  byte_i,
  output logic [CHIP_NUM-1:0]         en_o,
  output logic [8*CHIP_NUM-1:0]       data_o
);
  assign en_o = {1'b1, {(CHIP_NUM-1){1'b0}}} >> chip_i;
  assign data_o = {byte_i, {(8*CHIP_NUM-8){1'b0}}} >> {chip_i, 3'b000};
endmodule

// File: rtl/data_parse.sv
// data_parse: reads one packet back from packet RAM, checks its head and returns fields / ADC lanes.
module data_parse
  import data_parse_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fs,
  output logic                    fd,
  input  logic [3:0]              btype,
  input  logic [ADDR_W-1:0]       ram_data_init,
  output logic [ADDR_W-1:0]       ram_data_rxa,
  input  logic [7:0]              ram_data_rxd,
  output logic [CHIP_NUM-1:0]     fifo_adc_txen,
  output logic [8*CHIP_NUM-1:0]   fifo_adc_txd,
  output logic [3:0]              device_idx,
  output logic [3:0]              data_idx,
  output logic [3:0]              device_stat,
  output logic [7:0]              device_type,
  output logic [7:0]              device_temp,
  output logic                    dlink_ok,
  output logic                    err
);
  localparam int CW = $clog2(CHIP_NUM);
  localparam int LW = $clog2(DATA_LEN);
  localparam logic [11:0] LAST_DATA = 12'(DATA_LEN*CHIP_NUM + 1);
  state_e state_q;
  kind_e kind_q;
  logic vld_q;
  logic [11:0] acnt_q, bidx_q;
  logic [LW-1:0] cin_q;
  logic [CW-1:0] chip_q;
  logic [3:0] b0lo_q;
  logic [CHIP_NUM-1:0] en_d;
  logic [8*CHIP_NUM-1:0] lane_d;
  logic last_addr;
  adc_lane_demux u_demux (.chip_i(chip_q), .byte_i(ram_data_rxd), .en_o(en_d), .data_o(lane_d));
  assign fd = state_q == DONE;
  assign last_addr = acnt_q == (kind_q == K_DATA ? LAST_DATA : 12'd1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      kind_q <= K_DLINK;
      vld_q <= 1'b0;
      acnt_q <= '0;
      bidx_q <= '0;
      cin_q <= '0;
      chip_q <= '0;
      b0lo_q <= '0;
      ram_data_rxa <= DATA_ADDR_INIT;
      fifo_adc_txen <= '0;
      fifo_adc_txd <= '0;
      device_idx <= '0;
      data_idx <= '0;
      device_stat <= '0;
      device_type <= '0;
      device_temp <= '0;
      dlink_ok <= 1'b0;
      err <= 1'b0;
    end else begin
      vld_q <= state_q == READ;
      fifo_adc_txen <= '0;
      fifo_adc_txd <= '0;
      case (state_q)
        IDLE: state_q <= WAIT;
        WAIT: if (fs && btype_ok(btype)) begin
          state_q <= READ;
          kind_q <= kind_of(btype);
          ram_data_rxa <= ram_data_init;
          err <= 1'b0;
          acnt_q <= '0;
          bidx_q <= '0;
          cin_q <= '0;
          chip_q <= '0;
        end
        READ: if (last_addr) state_q <= LAST;
        else begin
          acnt_q <= acnt_q + 12'd1;
          ram_data_rxa <= ram_data_rxa + 1'b1;
        end
        LAST: state_q <= FLUSH;
        FLUSH: begin
          state_q <= DONE;
          ram_data_rxa <= DATA_ADDR_INIT;
        end
        DONE: if (!fs) state_q <= WAIT;
        default: state_q <= IDLE;
      endcase
      // byte returned for the address issued last cycle; a bad head mutes the rest of the job
      if (vld_q) begin
        bidx_q <= bidx_q + 12'd1;
        if (bidx_q == 12'd0) begin
          b0lo_q <= ram_data_rxd[3:0];
          if (ram_data_rxd[7:4] != head_of(kind_q)) err <= 1'b1;
          else device_idx <= ram_data_rxd[3:0];
        end else if (!err) begin
          if (bidx_q == 12'd1)
            case (kind_q)
              K_DLINK: dlink_ok <= {b0lo_q, ram_data_rxd} == DATA_DLINK;
              K_DTYPE: device_type <= ram_data_rxd;
              K_DTEMP: device_temp <= ram_data_rxd;
              default: {data_idx, device_stat} <= ram_data_rxd;
            endcase
          else begin
            fifo_adc_txen <= en_d;
            fifo_adc_txd <= lane_d;
            cin_q <= cin_q + 1'b1;
            if (&cin_q) chip_q <= chip_q + 1'b1;
          end
        end
      end
    end
endmodule
